// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle: stage register/control fields in, stall/flush/forward/divider controls out.
// master = pipeline side driving stage fields, slave = hazard_unit.
interface hazard_unit_if;
  logic [4:0] rsD, rtD;
  logic       branchD, pcsrcD, jumpD;
  logic [4:0] rsE, rtE, writeregE;
  logic       regwriteE, memtoregE, divE, hiloreadE;
  logic [4:0] writeregM;
  logic       regwriteM, memtoregM, hilowriteM;
  logic [4:0] writeregW;
  logic       regwriteW, hilowriteW;

  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushD, flushE, flushM;
  logic       forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE, forwardhiloE;
  logic       div_startE, div_doneE, div_busy;

  modport master (
    output rsD, rtD, branchD, pcsrcD, jumpD, rsE, rtE, writeregE, regwriteE, memtoregE,
           divE, hiloreadE, writeregM, regwriteM, memtoregM, hilowriteM, writeregW,
           regwriteW, hilowriteW,
    input  stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, forwardaD,
           forwardbD, forwardaE, forwardbE, forwardhiloE, div_startE, div_doneE, div_busy
  );

  modport slave (
    input  rsD, rtD, branchD, pcsrcD, jumpD, rsE, rtE, writeregE, regwriteE, memtoregE,
           divE, hiloreadE, writeregM, regwriteM, memtoregM, hilowriteM, writeregW,
           regwriteW, hilowriteW,
    output stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, forwardaD,
           forwardbD, forwardaE, forwardbE, forwardhiloE, div_startE, div_doneE, div_busy
  );
endinterface

// File: rtl/hazard_unit.sv
// 5-stage MIPS hazard unit: forwarding, load-use/branch stalls, multi-cycle divide sequencing.
// Optional HAZARD_PERF_EN adds saturating stall-cycle counters perf_lw/perf_br/perf_div.
module hazard_unit #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_unit_if.slave      hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_lw,
    output logic [PERF_W-1:0] perf_br,
    output logic [PERF_W-1:0] perf_div
`endif
);
    localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          div_start, div_done, busy;
    logic          lwstall, brstall, divstall;
    logic          hit_e_rs, hit_e_rt, hit_m_rs, hit_m_rt;
    logic [1:0]    fwd_a, fwd_b, fwd_hilo;

    // Register $0 is never a hazard source, so every destination match requires a nonzero reg.
    assign hit_e_rs = (hz.writeregE != 5'd0) && (hz.writeregE == hz.rsD);
    assign hit_e_rt = (hz.writeregE != 5'd0) && (hz.writeregE == hz.rtD);
    assign hit_m_rs = (hz.writeregM != 5'd0) && (hz.writeregM == hz.rsD);
    assign hit_m_rt = (hz.writeregM != 5'd0) && (hz.writeregM == hz.rtD);

    assign lwstall = hz.memtoregE && (hz.rtE != 5'd0) && ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));
    assign brstall = hz.branchD && ((hz.regwriteE && (hit_e_rs || hit_e_rt)) ||
                                    (hz.memtoregM && (hit_m_rs || hit_m_rt)));

    assign fwd_a = (hz.rsE != 5'd0 && hz.regwriteM && hz.writeregM == hz.rsE) ? 2'b10 :
                   (hz.rsE != 5'd0 && hz.regwriteW && hz.writeregW == hz.rsE) ? 2'b01 : 2'b00;
    assign fwd_b = (hz.rtE != 5'd0 && hz.regwriteM && hz.writeregM == hz.rtE) ? 2'b10 :
                   (hz.rtE != 5'd0 && hz.regwriteW && hz.writeregW == hz.rtE) ? 2'b01 : 2'b00;
    assign fwd_hilo = (hz.hiloreadE && hz.hilowriteM) ? 2'b10 :
                      (hz.hiloreadE && hz.hilowriteW) ? 2'b01 : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        div_start  = 1'b0;
        div_done   = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: if (hz.divE) begin
                div_start  = 1'b1;
                cnt_next   = CW'(DIV_CYCLES - 1);
                state_next = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == '0) state_next = DONE;
                else           cnt_next   = cnt - 1'b1;
            end
            DONE: begin
                div_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign divstall = div_start || busy;

    // Every control output is held inactive while reset is asserted, regardless of FSM state.
    assign hz.stallF       = rst && (lwstall || brstall || divstall);
    assign hz.stallD       = rst && (lwstall || brstall || divstall);
    assign hz.stallE       = rst && divstall;
    assign hz.stallM       = 1'b0;
    assign hz.stallW       = 1'b0;
    assign hz.flushE       = rst && (lwstall || brstall) && !divstall;
    assign hz.flushM       = rst && divstall;
    assign hz.flushD       = rst && (hz.pcsrcD || hz.jumpD) && !(lwstall || brstall || divstall);
    assign hz.forwardaD    = rst && hz.regwriteM && hit_m_rs;
    assign hz.forwardbD    = rst && hz.regwriteM && hit_m_rt;
    assign hz.forwardaE    = rst ? fwd_a : 2'b00;
    assign hz.forwardbE    = rst ? fwd_b : 2'b00;
    assign hz.forwardhiloE = rst ? fwd_hilo : 2'b00;
    assign hz.div_startE   = rst && div_start;
    assign hz.div_doneE    = rst && div_done;
    assign hz.div_busy     = rst && busy;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_lw  <= '0;
            perf_br  <= '0;
            perf_div <= '0;
        end else begin
            if (lwstall  && perf_lw  != '1) perf_lw  <= perf_lw  + 1'b1;
            if (brstall  && perf_br  != '1) perf_br  <= perf_br  + 1'b1;
            if (divstall && perf_div != '1) perf_div <= perf_div + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit (DIV_CYCLES=4): driver queues hand-computed output vectors,
// monitor compares them on the falling edge. Perf counters are checked when HAZARD_PERF_EN is set.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_unit_if hif ();

`ifdef HAZARD_PERF_EN
    logic [2:0] perf_lw, perf_br, perf_div;
    hazard_unit #(.DIV_CYCLES(4), .PERF_W(3)) dut (
        .clk(clk), .rst(rst), .hz(hif),
        .perf_lw(perf_lw), .perf_br(perf_br), .perf_div(perf_div));
`else
    hazard_unit #(.DIV_CYCLES(4)) dut (.clk(clk), .rst(rst), .hz(hif));
`endif

    typedef struct packed {
        logic       stall_f, stall_d, stall_e, stall_m, stall_w;
        logic       flush_d, flush_e, flush_m, fwd_ad, fwd_bd;
        logic [1:0] fwd_ae, fwd_be, fwd_hilo;
        logic       start, done, busy;
    } out_t;

    typedef struct {
        string name;
        out_t  exp;
    } item_t;

    item_t sb[$];
    int    total = 0;
    int    bad   = 0;
    out_t  e;

    function automatic out_t sample();
        out_t a;
        a = '{hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.stallW,
              hif.flushD, hif.flushE, hif.flushM, hif.forwardaD, hif.forwardbD,
              hif.forwardaE, hif.forwardbE, hif.forwardhiloE,
              hif.div_startE, hif.div_doneE, hif.div_busy};
        return a;
    endfunction

    function automatic out_t hz_stall();
        out_t r = '0;
        r.stall_f = 1'b1; r.stall_d = 1'b1; r.flush_e = 1'b1;
        return r;
    endfunction

    function automatic out_t div_stall();
        out_t r = '0;
        r.stall_f = 1'b1; r.stall_d = 1'b1; r.stall_e = 1'b1; r.flush_m = 1'b1;
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        item_t it;
        out_t  act;
        if (sb.size() > 0) begin
            it  = sb.pop_front();
            act = sample();
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL %s: got=%b want=%b", it.name, act, it.exp);
            end
        end
    end

    task automatic clear_in();
        hif.rsD = '0; hif.rtD = '0; hif.branchD = 1'b0; hif.pcsrcD = 1'b0; hif.jumpD = 1'b0;
        hif.rsE = '0; hif.rtE = '0; hif.writeregE = '0; hif.regwriteE = 1'b0;
        hif.memtoregE = 1'b0; hif.divE = 1'b0; hif.hiloreadE = 1'b0;
        hif.writeregM = '0; hif.regwriteM = 1'b0; hif.memtoregM = 1'b0; hif.hilowriteM = 1'b0;
        hif.writeregW = '0; hif.regwriteW = 1'b0; hif.hilowriteW = 1'b0;
    endtask

    task automatic step(input string name, input out_t exp);
        sb.push_back('{name, exp});
        @(posedge clk);
        #1;
    endtask

`ifdef HAZARD_PERF_EN
    task automatic check_perf(input string name, input logic [2:0] got, input logic [2:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        clear_in();
        // Busy inputs during reset: every output must still read inactive.
        hif.memtoregE = 1'b1; hif.rtE = 5'd2; hif.rsD = 5'd2; hif.divE = 1'b1;
        hif.regwriteM = 1'b1; hif.writeregM = 5'd5; hif.rsE = 5'd5; hif.branchD = 1'b1;
        hif.regwriteE = 1'b1; hif.writeregE = 5'd2; hif.pcsrcD = 1'b1;
        hif.hiloreadE = 1'b1; hif.hilowriteM = 1'b1;
        @(posedge clk); #1;
        step("reset0", '0);
        step("reset1", '0);
        rst = 1'b1;
        clear_in();

        hif.memtoregE = 1'b1; hif.regwriteE = 1'b1; hif.rtE = 5'd2; hif.writeregE = 5'd2; hif.rsD = 5'd2;
        step("lw_rs", hz_stall());
        hif.rsD = 5'd0; hif.rtD = 5'd0; hif.rtE = 5'd0; hif.writeregE = 5'd0;
        step("lw_r0", '0);
        hif.rtE = 5'd4; hif.writeregE = 5'd4; hif.rtD = 5'd4;
        step("lw_rt", hz_stall());
        clear_in();

        hif.regwriteM = 1'b1; hif.regwriteW = 1'b1; hif.writeregM = 5'd5; hif.writeregW = 5'd5;
        hif.rsE = 5'd5;
        e = '0; e.fwd_ae = 2'b10; step("fwd_a_m", e);
        hif.regwriteM = 1'b0;
        e = '0; e.fwd_ae = 2'b01; step("fwd_a_w", e);
        hif.rsE = 5'd0;
        step("fwd_a_r0", '0);
        hif.regwriteM = 1'b1; hif.rtE = 5'd5; hif.rtD = 5'd5;
        e = '0; e.fwd_be = 2'b10; e.fwd_bd = 1'b1; step("fwd_b_m", e);
        clear_in();
        hif.hiloreadE = 1'b1; hif.hilowriteM = 1'b1; hif.hilowriteW = 1'b1;
        e = '0; e.fwd_hilo = 2'b10; step("hilo_m", e);
        hif.hilowriteM = 1'b0;
        e = '0; e.fwd_hilo = 2'b01; step("hilo_w", e);
        hif.hiloreadE = 1'b0;
        step("hilo_none", '0);
        clear_in();

        hif.branchD = 1'b1; hif.rsD = 5'd3; hif.regwriteE = 1'b1; hif.writeregE = 5'd3;
        step("br_e", hz_stall());
        hif.regwriteE = 1'b0; hif.regwriteM = 1'b1; hif.writeregM = 5'd3;
        e = '0; e.fwd_ad = 1'b1; step("br_fwd", e);
        hif.pcsrcD = 1'b1;
        e.flush_d = 1'b1; step("br_taken", e);
        hif.memtoregM = 1'b1;
        e = hz_stall(); e.fwd_ad = 1'b1; step("br_ld_m", e);
        clear_in();
        hif.jumpD = 1'b1;
        e = '0; e.flush_d = 1'b1; step("jump", e);
        clear_in();

        hif.divE = 1'b1;
        e = div_stall(); e.start = 1'b1; step("div_c0", e);
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin
                hif.memtoregE = 1'b1; hif.rtE = 5'd2; hif.rsD = 5'd2;
            end else begin
                hif.memtoregE = 1'b0; hif.rtE = 5'd0; hif.rsD = 5'd0;
            end
            e = div_stall(); e.busy = 1'b1; step($sformatf("div_c%0d", c), e);
        end
        e = '0; e.done = 1'b1; step("div_done", e);
        e = div_stall(); e.start = 1'b1; step("div2_c0", e);
        e = div_stall(); e.busy = 1'b1; step("div2_c1", e);
        rst = 1'b0;
        step("div2_rst", '0);
        rst = 1'b1;
        e = div_stall(); e.start = 1'b1; step("div3_c0", e);
        for (int c = 1; c <= 4; c++) begin
            e = div_stall(); e.busy = 1'b1; step($sformatf("div3_c%0d", c), e);
        end
        hif.divE = 1'b0;
        e = '0; e.done = 1'b1; step("div3_done", e);
        step("div3_idle", '0);

`ifdef HAZARD_PERF_EN
        rst = 1'b0;
        clear_in();
        step("perf_rst", '0);
        check_perf("perf_lw_rst", perf_lw, 3'd0);
        check_perf("perf_br_rst", perf_br, 3'd0);
        check_perf("perf_div_rst", perf_div, 3'd0);
        rst = 1'b1;
        hif.divE = 1'b1;
        e = div_stall(); e.start = 1'b1; step("pdiv_c0", e);
        for (int c = 1; c <= 4; c++) begin
            e = div_stall(); e.busy = 1'b1; step("pdiv_busy", e);
        end
        hif.divE = 1'b0;
        e = '0; e.done = 1'b1; step("pdiv_done", e);
        check_perf("perf_div", perf_div, 3'd5);
        hif.memtoregE = 1'b1; hif.rtE = 5'd2; hif.rsD = 5'd2;
        for (int c = 0; c < 10; c++) step("plw", hz_stall());
        check_perf("perf_lw_sat", perf_lw, 3'd7);
        clear_in();
        hif.branchD = 1'b1; hif.rsD = 5'd3; hif.regwriteE = 1'b1; hif.writeregE = 5'd3;
        step("pbr0", hz_stall());
        step("pbr1", hz_stall());
        clear_in();
        step("pidle", '0);
        check_perf("perf_br", perf_br, 3'd2);
        check_perf("perf_div_hold", perf_div, 3'd5);
`endif

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
